pi_txn_queue: RTL and testbench
===============================

# pi_txn_queue

Pi-side transaction queue between the Pi GPIO register interface and the 68k bus-cycle sequencer. Assembles Pi register writes (data, address-low, address-high/flags) into complete 68k bus requests. Buffers them in a small FIFO so the Pi can post writes back-to-back. Issues them one at a time to the sequencer over a valid/ready request and done-pulse response handshake, and returns read data and status to the Pi.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- PI_CLK  in  1  200 MHz Pi-domain clock; all logic rising-edge
- PI_RST  in  1  synchronous, active-high reset
- wr_stb  in  1  one-cycle pulse: Pi register write (already synchronised/edge-detected)
- rd_stb  in  1  one-cycle pulse: Pi register read
- reg_a  in  2  register select: 0 DATA, 1 ADDR_LO, 2 ADDR_HI, 3 STATUS
- wr_d  in  16  Pi write data
- rd_d  out  16  Pi read data, combinational on reg_a
- req_valid  out  1  request to sequencer
- req_ready  in  1  sequencer accepts request
- req_addr  out  24  68k byte address
- req_wdata  out  16  write data
- req_rw  out  1  1 = read
- req_uds_n, req_lds_n  out  1 each  data strobes
- rsp_valid  in  1  one-cycle pulse: bus cycle finished (S7)
- rsp_rdata  in  16  read data, valid with rsp_valid
- txn_busy  out  1  drives PI_TXN_IN_PROGRESS
- overflow  out  1  sticky: a commit was dropped

## Operation
- DATA write: wdata_r <= wr_d. ADDR_LO write: addr_r[15:0] <= wr_d.
- ADDR_HI write is the commit:
  - entry = {addr_r[23:16]=wr_d[7:0], addr_r[15:0], wdata_r, rw=wr_d[9], size_byte=wr_d[8]}.
  - Strobes: byte: uds_n=addr[0], lds_n=!addr[0]. Word: both 0.
  - Pushed into the FIFO.
- STATUS write: bit0 set clears overflow; other bits ignored.
- FIFO push rules:
  - Push accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the entry is dropped and overflow <= 1.
- Issue FSM, states IDLE, ISSUE, WAIT:
  - IDLE -> ISSUE when FIFO non-empty; head loaded into req_* registers.
  - ISSUE holds req_valid=1 with stable req_*; on req_ready: pop, -> WAIT.
  - WAIT -> IDLE on rsp_valid; if req_rw was 1, rdata_r <= rsp_rdata.
  - rsp_valid outside WAIT is ignored.
- Read data (rd_d):
  - reg_a=DATA: rdata_r.
  - reg_a=STATUS: {txn_busy, overflow, 9'd0, count[4:0]}, with count zero-extended.
  - Any other reg_a: 16'h0000.
  - rd_stb has no side effect.
- txn_busy = (count!=0) || state!=IDLE, registered.

## Timing
- Reset values: req_valid 0; req_addr, req_wdata, rdata_r, wdata_r, addr_r all 0; req_rw 1; req_uds_n and req_lds_n 1; txn_busy 0; overflow 0; count 0; state IDLE.
- Commit at cycle N: count updates at N+1, txn_busy=1 at N+1, req_valid=1 at N+2 when the FSM was idle.
- req_ready sampled only while req_valid=1; the pop happens in the same cycle, and FSM is in WAIT the next cycle.
- Back-to-back: after rsp_valid at cycle M, the next req_valid rises at M+2 (IDLE at M+1).
- Full FIFO (count=DEPTH) plus a commit in a pop cycle: both occur, count unchanged, no overflow.
- Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- txn_busy falls the cycle after the last rsp_valid with an empty FIFO.
- Sticky overflow survives a STATUS write whose bit0=0; cleared only by a bit0=1 write or by reset.
- PI_RST mid-transaction:
  - FIFO flushed, FSM to IDLE, req_valid drops the next cycle.
  - A pending rsp_valid in the reset cycle is discarded.
- Simultaneous wr_stb to ADDR_HI and rsp_valid: both take effect.

## Structure
- Shared package pistorm_pkg: REG_DATA/REG_ADDR_LO/REG_ADDR_HI/REG_STATUS constants, the txn entry struct {addr[23:0], wdata[15:0], rw, uds_n, lds_n}, the issue-FSM state enum, and the STATUS bit positions.
- One sub-module: pi_txn_fifo (parameterised sync FIFO on PI_CLK/PI_RST with push/pop/full/empty/count).

## Test plan
- Reset, then write DATA=0xBEEF, ADDR_LO=0x1234, ADDR_HI=0x0056 -> req_valid at N+2 with addr 0x561234, wdata 0xBEEF, rw 0, uds_n 0, lds_n 0; with req_ready=1 and rsp_valid 5 cycles later, txn_busy=0 the cycle after.
- Byte read: ADDR_LO=0x0001, ADDR_HI=0x0300 -> rw 1, uds_n 1, lds_n 0. rsp_rdata=0x00A5 -> DATA readback 0x00A5.
- Hold req_ready=0 and commit 5 writes with DEPTH=4 -> count 4, overflow=1, STATUS=0xC004. STATUS write 0x0001 -> overflow 0.
- FIFO full with a commit in the req_ready cycle -> entry accepted, count stays 4, overflow 0.
- Assert PI_RST while in WAIT with 2 queued -> next cycle req_valid 0, count 0, txn_busy 0. A later rsp_valid does not change rdata_r.
- Three queued writes with req_ready=1 and rsp_valid 3 cycles after each accept -> issued in FIFO order with correct addresses, at 2-cycle IDLE gaps.

Source files
------------

// File: rtl/pistorm_pkg.sv
// Shared definitions for the Pi-side transaction path.
// Contents: Pi register select codes, STATUS bit positions, the queued
// transaction entry, the issue-FSM state encoding and an entry builder.
package pistorm_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_ADDR_LO = 2'd1;
  localparam logic [1:0] REG_ADDR_HI = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int STAT_BUSY_BIT    = 15;
  localparam int STAT_OVF_BIT     = 14;
  localparam int STAT_CLR_OVF_BIT = 0;
  localparam int STAT_CNT_W       = 5;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] wdata;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
  } txn_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } issue_state_e;

  // Byte cycles strobe the lane selected by addr[0] (even = upper byte);
  // word cycles strobe both lanes.
  function automatic txn_t make_txn(input logic [23:0] addr,
                                    input logic [15:0] wdata,
                                    input logic        rw,
                                    input logic        size_byte);
    txn_t t;
    t.addr  = addr;
    t.wdata = wdata;
    t.rw    = rw;
    t.uds_n = size_byte ? addr[0]  : 1'b0;
    t.lds_n = size_byte ? ~addr[0] : 1'b0;
    return t;
  endfunction

endpackage

// File: rtl/pi_txn_fifo.sv
// Synchronous FIFO of txn_t entries on the Pi clock.
// Ports: PI_CLK/PI_RST clock and sync active-high reset; push_i/din_i write
// side; pop_i/dout_o read side (dout_o shows the head); full_o/empty_o flags;
// count_o occupancy and count_nxt_o next-cycle occupancy; push_ok_o push
// accepted; drop_o push refused because the FIFO was full with no pop.
module pi_txn_fifo
  import pistorm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   PI_CLK,
  input  logic                   PI_RST,
  input  logic                   push_i,
  input  txn_t                   din_i,
  input  logic                   pop_i,
  output txn_t                   dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [$clog2(DEPTH):0] count_nxt_o,
  output logic                   push_ok_o,
  output logic                   drop_o
);

  localparam int PTR_W = $clog2(DEPTH);

  txn_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             pop_eff;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
  assign pop_eff   = pop_i & ~empty_o;
  assign push_ok_o = push_i & (~full_o | pop_eff);
  assign drop_o    = push_i & full_o & ~pop_eff;

  // Pointers are log2(DEPTH) bits wide, so they wrap modulo DEPTH naturally.
  always_comb begin
    wptr_d  = wptr_q + PTR_W'(push_ok_o);
    rptr_d  = rptr_q + PTR_W'(pop_eff);
    count_d = count_q + (PTR_W+1)'(push_ok_o) - (PTR_W+1)'(pop_eff);
  end

  assign count_o     = count_q;
  assign count_nxt_o = count_d;

  always_ff @(posedge PI_CLK) begin
    if (PI_RST) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge PI_CLK) begin
    if (push_ok_o) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/pi_txn_queue.sv
// Pi-side transaction queue feeding the 68k bus-cycle sequencer.
// Ports: PI_CLK/PI_RST clock and sync active-high reset; wr_stb/rd_stb/reg_a/
// wr_d/rd_d Pi register access (rd_d combinational on reg_a); req_* request
// to the sequencer (valid/ready); rsp_valid/rsp_rdata completion pulse and
// read data; txn_busy queue or bus cycle outstanding; overflow sticky drop flag.
module pi_txn_queue
  import pistorm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        PI_CLK,
  input  logic        PI_RST,
  input  logic        wr_stb,
  input  logic        rd_stb,
  input  logic [1:0]  reg_a,
  input  logic [15:0] wr_d,
  output logic [15:0] rd_d,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [23:0] req_addr,
  output logic [15:0] req_wdata,
  output logic        req_rw,
  output logic        req_uds_n,
  output logic        req_lds_n,
  input  logic        rsp_valid,
  input  logic [15:0] rsp_rdata,
  output logic        txn_busy,
  output logic        overflow
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam txn_t REQ_RST = '{addr: 24'h0, wdata: 16'h0, rw: 1'b1,
                               uds_n: 1'b1, lds_n: 1'b1};

  issue_state_e     state_q, state_d;
  txn_t             req_q;
  logic [15:0]      wdata_q;
  logic [23:0]      addr_q;
  logic [15:0]      rdata_q;
  logic             overflow_q;
  logic             busy_q, busy_d;

  logic             wr_data, wr_lo, wr_hi, wr_stat;
  txn_t             commit_txn;
  txn_t             head;
  logic             fifo_full, fifo_empty, push_ok, drop;
  logic [CNT_W-1:0] fifo_count, fifo_count_nxt;
  logic             load_req, pop, cap_rd;

  // Reads have no side effects.
  logic unused_rd_stb;
  assign unused_rd_stb = rd_stb;

  assign wr_data = wr_stb & (reg_a == REG_DATA);
  assign wr_lo   = wr_stb & (reg_a == REG_ADDR_LO);
  assign wr_hi   = wr_stb & (reg_a == REG_ADDR_HI);
  assign wr_stat = wr_stb & (reg_a == REG_STATUS);

  // ADDR_HI supplies addr[23:16] and the cycle flags, and commits the entry.
  assign commit_txn = make_txn({wr_d[7:0], addr_q[15:0]}, wdata_q,
                               wr_d[9], wr_d[8]);

  pi_txn_fifo #(.DEPTH(DEPTH)) u_fifo (
    .PI_CLK      (PI_CLK),
    .PI_RST      (PI_RST),
    .push_i      (wr_hi),
    .din_i       (commit_txn),
    .pop_i       (pop),
    .dout_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .count_nxt_o (fifo_count_nxt),
    .push_ok_o   (push_ok),
    .drop_o      (drop)
  );

  // Issue FSM: the head stays in the FIFO until the sequencer accepts it.
  always_comb begin
    state_d  = state_q;
    load_req = 1'b0;
    pop      = 1'b0;
    cap_rd   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d  = S_ISSUE;
          load_req = 1'b1;
        end
      end
      S_ISSUE: begin
        if (req_ready) begin
          pop     = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_valid) begin
          state_d = S_IDLE;
          cap_rd  = req_q.rw;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Busy is registered from next-cycle occupancy and state.
  assign busy_d = (fifo_count_nxt != '0) || (state_d != S_IDLE);

  always_ff @(posedge PI_CLK) begin
    if (PI_RST) begin
      state_q    <= S_IDLE;
      req_q      <= REQ_RST;
      wdata_q    <= '0;
      addr_q     <= '0;
      rdata_q    <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      if (load_req) req_q <= head;
      if (cap_rd)   rdata_q <= rsp_rdata;
      if (wr_data)  wdata_q <= wr_d;
      if (wr_lo)    addr_q[15:0] <= wr_d;
      if (wr_hi)    addr_q[23:16] <= wr_d[7:0];
      if (drop)
        overflow_q <= 1'b1;
      else if (wr_stat && wr_d[STAT_CLR_OVF_BIT])
        overflow_q <= 1'b0;
    end
  end

  always_comb begin
    rd_d = 16'h0000;
    case (reg_a)
      REG_DATA: rd_d = rdata_q;
      REG_STATUS: begin
        rd_d[STAT_BUSY_BIT]     = busy_q;
        rd_d[STAT_OVF_BIT]      = overflow_q;
        rd_d[STAT_CNT_W-1:0]    = STAT_CNT_W'(fifo_count);
      end
      default: rd_d = 16'h0000;
    endcase
  end

  assign req_valid = (state_q == S_ISSUE);
  assign req_addr  = req_q.addr;
  assign req_wdata = req_q.wdata;
  assign req_rw    = req_q.rw;
  assign req_uds_n = req_q.uds_n;
  assign req_lds_n = req_q.lds_n;
  assign txn_busy  = busy_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pi_txn_queue.sv
module tb_pi_txn_queue;

  logic        PI_CLK;
  logic        PI_RST;
  logic        wr_stb;
  logic        rd_stb;
  logic [1:0]  reg_a;
  logic [15:0] wr_d;
  logic [15:0] rd_d;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_rw;
  logic        req_uds_n;
  logic        req_lds_n;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        txn_busy;
  logic        overflow;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  pi_txn_queue #(.DEPTH(4)) dut (
    .PI_CLK    (PI_CLK),
    .PI_RST    (PI_RST),
    .wr_stb    (wr_stb),
    .rd_stb    (rd_stb),
    .reg_a     (reg_a),
    .wr_d      (wr_d),
    .rd_d      (rd_d),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_rw    (req_rw),
    .req_uds_n (req_uds_n),
    .req_lds_n (req_lds_n),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .txn_busy  (txn_busy),
    .overflow  (overflow)
  );

  initial begin
    PI_CLK = 1'b0;
    forever #5 PI_CLK = ~PI_CLK;
  end

  always @(posedge PI_CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge PI_CLK);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    reg_a  = a;
    wr_d   = d;
    wr_stb = 1'b1;
    step();
    wr_stb = 1'b0;
  endtask

  task automatic test_reset();
    PI_RST = 1'b1;
    step();
    step();
    PI_RST = 1'b0;
    tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL rst_req_valid got %b exp 0", req_valid); end
    tests++; if (req_rw !== 1'b1) begin fails++; $display("FAIL rst_req_rw got %b exp 1", req_rw); end
    tests++; if ({req_uds_n, req_lds_n} !== 2'b11) begin fails++; $display("FAIL rst_strobes got %b exp 11", {req_uds_n, req_lds_n}); end
    tests++; if (req_addr !== 24'h0 || req_wdata !== 16'h0) begin fails++; $display("FAIL rst_req_data got %h/%h exp 0/0", req_addr, req_wdata); end
    tests++; if (txn_busy !== 1'b0 || overflow !== 1'b0) begin fails++; $display("FAIL rst_flags got busy %b ovf %b exp 0 0", txn_busy, overflow); end
    reg_a = 2'd3; #1;
    tests++; if (rd_d !== 16'h0000) begin fails++; $display("FAIL rst_status got %h exp 0000", rd_d); end
    reg_a = 2'd0; #1;
    tests++; if (rd_d !== 16'h0000) begin fails++; $display("FAIL rst_rdata got %h exp 0000", rd_d); end
    reg_a = 2'd1; #1;
    tests++; if (rd_d !== 16'h0000) begin fails++; $display("FAIL rst_rd_addrlo got %h exp 0000", rd_d); end
  endtask

  task automatic test_word_write();
    wr(2'd0, 16'hBEEF);
    wr(2'd1, 16'h1234);
    wr(2'd2, 16'h0056);
    tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL ww_valid_n1 got %b exp 0", req_valid); end
    tests++; if (txn_busy !== 1'b1) begin fails++; $display("FAIL ww_busy_n1 got %b exp 1", txn_busy); end
    reg_a = 2'd3; #1;
    tests++; if (rd_d !== 16'h8001) begin fails++; $display("FAIL ww_status_n1 got %h exp 8001", rd_d); end
    step();
    tests++; if (req_valid !== 1'b1) begin fails++; $display("FAIL ww_valid_n2 got %b exp 1", req_valid); end
    tests++; if (req_addr !== 24'h561234) begin fails++; $display("FAIL ww_addr got %h exp 561234", req_addr); end
    tests++; if (req_wdata !== 16'hBEEF) begin fails++; $display("FAIL ww_wdata got %h exp beef", req_wdata); end
    tests++; if ({req_rw, req_uds_n, req_lds_n} !== 3'b000) begin fails++; $display("FAIL ww_flags got %b exp 000", {req_rw, req_uds_n, req_lds_n}); end
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL ww_wait_valid got %b exp 0", req_valid); end
    #1;
    tests++; if (rd_d !== 16'h8000) begin fails++; $display("FAIL ww_status_wait got %h exp 8000", rd_d); end
    for (int i = 0; i < 4; i++) step();
    rsp_valid = 1'b1;
    rsp_rdata = 16'hFFFF;
    tests++; if (txn_busy !== 1'b1) begin fails++; $display("FAIL ww_busy_before_rsp got %b exp 1", txn_busy); end
    step();
    rsp_valid = 1'b0;
    tests++; if (txn_busy !== 1'b0) begin fails++; $display("FAIL ww_busy_after_rsp got %b exp 0", txn_busy); end
    reg_a = 2'd0; #1;
    tests++; if (rd_d !== 16'h0000) begin fails++; $display("FAIL ww_no_capture got %h exp 0000", rd_d); end
  endtask

  task automatic test_byte_read();
    wr(2'd1, 16'h0001);
    wr(2'd2, 16'h0300);
    step();
    tests++; if (req_valid !== 1'b1) begin fails++; $display("FAIL br_valid got %b exp 1", req_valid); end
    tests++; if (req_addr !== 24'h000001) begin fails++; $display("FAIL br_addr got %h exp 000001", req_addr); end
    tests++; if ({req_rw, req_uds_n, req_lds_n} !== 3'b110) begin fails++; $display("FAIL br_flags got %b exp 110", {req_rw, req_uds_n, req_lds_n}); end
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    step();
    rsp_valid = 1'b1;
    rsp_rdata = 16'h00A5;
    step();
    rsp_valid = 1'b0;
    reg_a = 2'd0; #1;
    tests++; if (rd_d !== 16'h00A5) begin fails++; $display("FAIL br_rdata got %h exp 00a5", rd_d); end
    rsp_valid = 1'b1;
    rsp_rdata = 16'h1111;
    step();
    rsp_valid = 1'b0;
    #1;
    tests++; if (rd_d !== 16'h00A5) begin fails++; $display("FAIL br_idle_rsp got %h exp 00a5", rd_d); end
  endtask

  task automatic test_overflow();
    req_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(2'd2, 16'h0010 + 16'(i));
    reg_a = 2'd3; #1;
    tests++; if (rd_d !== 16'hC004) begin fails++; $display("FAIL ov_status got %h exp c004", rd_d); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ov_flag got %b exp 1", overflow); end
    wr(2'd3, 16'h0000);
    #1;
    tests++; if (rd_d !== 16'hC004) begin fails++; $display("FAIL ov_sticky got %h exp c004", rd_d); end
    wr(2'd3, 16'h0001);
    #1;
    tests++; if (rd_d !== 16'h8004) begin fails++; $display("FAIL ov_clear got %h exp 8004", rd_d); end
  endtask

  task automatic test_full_pop_push();
    tests++; if (req_valid !== 1'b1) begin fails++; $display("FAIL fp_valid got %b exp 1", req_valid); end
    req_ready = 1'b1;
    wr(2'd2, 16'h0077);
    req_ready = 1'b0;
    tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL fp_wait got %b exp 0", req_valid); end
    reg_a = 2'd3; #1;
    tests++; if (rd_d !== 16'h8004) begin fails++; $display("FAIL fp_status got %h exp 8004", rd_d); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL fp_ovf got %b exp 0", overflow); end
  endtask

  task automatic test_reset_mid();
    PI_RST = 1'b1;
    step();
    PI_RST = 1'b0;
    for (int i = 0; i < 3; i++) wr(2'd2, 16'h0201 + 16'(i));
    tests++; if (req_valid !== 1'b1) begin fails++; $display("FAIL rm_valid got %b exp 1", req_valid); end
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    reg_a = 2'd3; #1;
    tests++; if (rd_d !== 16'h8002) begin fails++; $display("FAIL rm_status_wait got %h exp 8002", rd_d); end
    PI_RST    = 1'b1;
    rsp_valid = 1'b1;
    rsp_rdata = 16'hDEAD;
    step();
    PI_RST    = 1'b0;
    rsp_valid = 1'b0;
    tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL rm_valid_after got %b exp 0", req_valid); end
    tests++; if (txn_busy !== 1'b0) begin fails++; $display("FAIL rm_busy got %b exp 0", txn_busy); end
    #1;
    tests++; if (rd_d !== 16'h0000) begin fails++; $display("FAIL rm_status got %h exp 0000", rd_d); end
    step();
    step();
    tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL rm_flushed got %b exp 0", req_valid); end
    rsp_valid = 1'b1;
    rsp_rdata = 16'h5555;
    step();
    rsp_valid = 1'b0;
    reg_a = 2'd0; #1;
    tests++; if (rd_d !== 16'h0000) begin fails++; $display("FAIL rm_rdata got %h exp 0000", rd_d); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] lo   [3];
    logic [15:0] hi   [3];
    logic [23:0] eadr [3];
    logic [1:0]  estb [3];
    int          rsp_cyc;
    int          n;
    lo[0] = 16'h1000; hi[0] = 16'h00AA; eadr[0] = 24'hAA1000; estb[0] = 2'b00;
    lo[1] = 16'h1002; hi[1] = 16'h01AA; eadr[1] = 24'hAA1002; estb[1] = 2'b01;
    lo[2] = 16'h1004; hi[2] = 16'h00AA; eadr[2] = 24'hAA1004; estb[2] = 2'b00;
    req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr(2'd0, 16'h1110 + 16'(i));
      wr(2'd1, lo[i]);
      wr(2'd2, hi[i]);
    end
    req_ready = 1'b1;
    rsp_cyc = 0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (req_valid !== 1'b1 && n < 20) begin
        step();
        n++;
      end
      tests++; if (req_valid !== 1'b1) begin fails++; $display("FAIL b2b_timeout[%0d] got valid %b exp 1", k, req_valid); end
      if (k > 0) begin
        tests++; if (cyc - rsp_cyc !== 2) begin fails++; $display("FAIL b2b_gap[%0d] got %0d exp 2", k, cyc - rsp_cyc); end
      end
      tests++; if (req_addr !== eadr[k]) begin fails++; $display("FAIL b2b_addr[%0d] got %h exp %h", k, req_addr, eadr[k]); end
      tests++; if (req_wdata !== 16'h1110 + 16'(k)) begin fails++; $display("FAIL b2b_wdata[%0d] got %h exp %h", k, req_wdata, 16'h1110 + 16'(k)); end
      tests++; if ({req_uds_n, req_lds_n} !== estb[k]) begin fails++; $display("FAIL b2b_strobes[%0d] got %b exp %b", k, {req_uds_n, req_lds_n}, estb[k]); end
      step();
      tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL b2b_wait[%0d] got %b exp 0", k, req_valid); end
      step();
      step();
      rsp_valid = 1'b1;
      rsp_rdata = 16'h0000;
      rsp_cyc   = cyc;
      step();
      rsp_valid = 1'b0;
    end
    req_ready = 1'b0;
    tests++; if (txn_busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_end got %b exp 0", txn_busy); end
  endtask

  initial begin
    PI_RST    = 1'b1;
    wr_stb    = 1'b0;
    rd_stb    = 1'b0;
    reg_a     = 2'd0;
    wr_d      = 16'h0000;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 16'h0000;
    test_reset();
    test_word_write();
    test_byte_read();
    test_overflow();
    test_full_pop_push();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
